mouse_position_tracker: RTL and testbench
=========================================

Name: mouse_position_tracker

Overview:
Parametrised successor to the transceiver's built-in X/Y accumulator. It consumes decoded PS/2 packets (3-byte standard or 4-byte wheel) from the master state machine and tracks absolute cursor X/Y and wheel Z. Adds runtime-programmable limits, saturate/wrap modes, Y inversion, sensitivity division with residual carry, sticky button-press flags, and an acknowledged interrupt with overrun counting. It sits between the master state machine and the bus/VGA consumers.

Parameters:
POS_WIDTH, 10, width of POS_X/POS_Y and limit registers.
LIMIT_X, 160, reset X limit; POS_X range is 0..limit-1.
LIMIT_Y, 120, reset Y limit.
Z_ENABLE, 1, 1 = wheel byte used; 0 = POS_Z tied to 0.
Z_WIDTH, 8, signed width of the Z accumulator.
DIV_SHIFT, 0, sensitivity: the applied step is delta/2^DIV_SHIFT; the remainder carries forward.

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
PKT_VALID  in  1  one-cycle strobe: packet fields valid
PKT_STATUS  in  8  PS/2 byte 0 (bits 7/6 Y/X overflow, 5/4 Y/X sign, 2:0 buttons)
PKT_DX  in  8  X delta low byte
PKT_DY  in  8  Y delta low byte
PKT_DZ  in  8  signed wheel delta; ignored when Z_ENABLE=0
CFG_WE  in  1  config write strobe
CFG_ADDR  in  2  0 = limitX, 1 = limitY, 2 = mode (bit0 wrap, bit1 invertY), 3 = recentre
CFG_WDATA  in  POS_WIDTH  config data
POS_X  out  POS_WIDTH  cursor X
POS_Y  out  POS_WIDTH  cursor Y
POS_Z  out  Z_WIDTH  signed wheel accumulator, saturating
BUTTONS  out  3  latched buttons from the last packet
BTN_PRESSED  out  3  sticky flags for 0->1 button transitions
INTR  out  1  update-pending interrupt
INTR_ACK  in  1  clears INTR and BTN_PRESSED
OVERRUN_COUNT  out  8  count of updates that arrived while INTR was already high; saturates at 255

Behaviour:
- Reset values:
  - POS_X = LIMIT_X/2; POS_Y = LIMIT_Y/2.
  - POS_Z, BUTTONS, BTN_PRESSED, INTR, OVERRUN_COUNT = 0.
  - Residuals = 0; limits = parameter values; mode = 0.
  - Reset mid-operation discards any in-flight packet.
- Stage 1 (cycle after PKT_VALID): form 9-bit signed deltas.
  - X: status[6] set -> status[4] ? -256 : +255; otherwise {status[4], DX}. Y uses bits 7/5 and DY.
  - invertY negates dy.
  - DZ is sign-extended.
- Stage 2 (the following cycle), per axis:
  - total = residual + delta.
  - step = total >>> DIV_SHIFT (floor).
  - residual = total - (step << DIV_SHIFT), range 0..2^DIV_SHIFT-1.
  - new = pos + step, computed at POS_WIDTH+2 signed.
- Saturate mode: new < 0 -> 0; new > limit-1 -> limit-1.
- Wrap mode:
  - new < 0 -> new + limit; new >= limit -> new - limit.
  - If still out of range, saturate as above.
- Z: POS_Z + dz, saturated to the Z_WIDTH signed range, never wraps.
- Latency: outputs update exactly 2 cycles after PKT_VALID.
  - PKT_VALID on consecutive cycles is fully pipelined; each packet sees the previous packet's result.
- BUTTONS takes status[2:0] at the stage-2 update; a 0->1 bit transition sets the matching BTN_PRESSED bit.
- Interrupt FSM, IDLE / PENDING:
  - An update moves the FSM to PENDING and sets INTR in the same cycle the outputs change.
  - INTR_ACK in PENDING returns to IDLE and clears BTN_PRESSED.
  - Update and ACK in the same cycle: stays PENDING; only the new presses are set; no overrun is counted.
  - Update while PENDING without ACK: OVERRUN_COUNT increments, saturating.
  - ACK while IDLE: no effect.
- Config:
  - Limit writes take effect the next cycle. A written value of 0 is ignored.
  - Every cycle, positions are clamped to limit-1 against the current limit registers, so shrinking a limit clamps the cursor the cycle after the write.
  - Recentre (addr 3) sets pos = limit/2, Z = 0, residuals = 0. If it coincides with a stage-2 update, recentre wins for positions, while buttons and INTR still update.

Decomposition:
- Package mouse_pkg holds:
  - status bit indices (OVF_Y=7, OVF_X=6, SGN_Y=5, SGN_X=4);
  - CFG address constants;
  - mode bit indices;
  - IDLE/PENDING state encoding.
- Sub-module mouse_axis_accum: residual, divide, wrap/saturate and limit clamp for one axis. It is instantiated twice, for X and Y. Z stays inline.

Test Plan:
- Reset, then packet status=0x00, DX=0x05, DY=0x03 -> 2 cycles after PKT_VALID: POS_X=85, POS_Y=63, INTR=1. INTR_ACK -> INTR=0.
- Saturate at X=150 with status=0x40 (X overflow, positive) -> POS_X=159. With status=0x50 -> POS_X=0.
- Wrap mode (mode=1) at X=158 with DX=+5 -> POS_X=3. Then DX=-10 (status=0x10, DX=0xF6) -> POS_X=153.
- DIV_SHIFT=2 bench, five packets of DX=+1 -> POS_X = 80, 80, 80, 81, 81 (residual carry).
- Status 0x01 without ACK, then 0x03 -> BTN_PRESSED=3'b011, OVERRUN_COUNT=1. ACK in the same cycle as a third update -> INTR stays 1 and OVERRUN_COUNT stays 1.
- Write limitX=50 with POS_X=80 -> POS_X=49 the cycle after the write. Then recentre -> POS_X=25, POS_Y=60, POS_Z=0.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared constants, state encoding and delta decoding for the mouse position tracker.
package mouse_pkg;

  localparam int unsigned OVF_Y = 7;
  localparam int unsigned OVF_X = 6;
  localparam int unsigned SGN_Y = 5;
  localparam int unsigned SGN_X = 4;

  localparam int unsigned DELTA_WIDTH = 10;

  localparam logic [1:0] CFG_LIMIT_X  = 2'd0;
  localparam logic [1:0] CFG_LIMIT_Y  = 2'd1;
  localparam logic [1:0] CFG_MODE     = 2'd2;
  localparam logic [1:0] CFG_RECENTRE = 2'd3;

  localparam int unsigned MODE_WRAP     = 0;
  localparam int unsigned MODE_INVERT_Y = 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } intrState_e;

  // Overflowed axes pin to the extreme 9-bit value in the direction of the sign bit.
  function automatic logic signed [DELTA_WIDTH-1:0] formDelta(input logic ovf,
                                                             input logic sgn,
                                                             input logic [7:0] low);
    logic signed [DELTA_WIDTH-1:0] d;
    if (ovf) d = sgn ? -DELTA_WIDTH'(256) : DELTA_WIDTH'(255);
    else     d = DELTA_WIDTH'($signed({sgn, low}));
    return d;
  endfunction

endpackage

// File: rtl/mouse_position_tracker_if.sv
// Packet, config and cursor-state signals between the master state machine and the tracker.
interface mouse_position_tracker_if #(
  parameter int unsigned POS_WIDTH = 10,
  parameter int unsigned Z_WIDTH   = 8
);
  logic                        PKT_VALID;
  logic [7:0]                  PKT_STATUS;
  logic [7:0]                  PKT_DX;
  logic [7:0]                  PKT_DY;
  logic [7:0]                  PKT_DZ;
  logic                        CFG_WE;
  logic [1:0]                  CFG_ADDR;
  logic [POS_WIDTH-1:0]        CFG_WDATA;
  logic                        INTR_ACK;
  logic [POS_WIDTH-1:0]        POS_X;
  logic [POS_WIDTH-1:0]        POS_Y;
  logic signed [Z_WIDTH-1:0]   POS_Z;
  logic [2:0]                  BUTTONS;
  logic [2:0]                  BTN_PRESSED;
  logic                        INTR;
  logic [7:0]                  OVERRUN_COUNT;

  modport master (
    output PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY, PKT_DZ,
    output CFG_WE, CFG_ADDR, CFG_WDATA, INTR_ACK,
    input  POS_X, POS_Y, POS_Z, BUTTONS, BTN_PRESSED, INTR, OVERRUN_COUNT
  );

  modport slave (
    input  PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY, PKT_DZ,
    input  CFG_WE, CFG_ADDR, CFG_WDATA, INTR_ACK,
    output POS_X, POS_Y, POS_Z, BUTTONS, BTN_PRESSED, INTR, OVERRUN_COUNT
  );
endinterface

// File: rtl/mouse_axis_accum.sv
// One cursor axis: residual-carrying divide, wrap/saturate against the live limit, recentre.
module mouse_axis_accum
  import mouse_pkg::*;
#(
  parameter int unsigned POS_WIDTH = 10,
  parameter int unsigned DIV_SHIFT = 0,
  parameter int unsigned RESET_POS = 80
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          deltaValid,
  input  logic signed [DELTA_WIDTH-1:0] delta,
  input  logic [POS_WIDTH-1:0]          limit,
  input  logic                          wrapMode,
  input  logic                          recentre,
  output logic [POS_WIDTH-1:0]          pos
);
  localparam int unsigned SW = POS_WIDTH + 2;
  localparam int unsigned TW = DELTA_WIDTH + DIV_SHIFT + 1;
  localparam int unsigned RW = (DIV_SHIFT > 0) ? DIV_SHIFT : 1;
  localparam logic signed [SW-1:0] S_ZERO = '0;

  logic [RW-1:0]          residual, residualNext, residualCalc;
  logic signed [TW-1:0]   total, step;
  logic signed [SW-1:0]   limitS, limitM1S, raw, wrapped, sat;
  logic [POS_WIDTH-1:0]   limitM1, posNext;

  always_comb begin
    total        = $signed({{(TW-RW){1'b0}}, residual}) + TW'(delta);
    step         = total >>> DIV_SHIFT;
    // Floor division leaves the non-negative remainder in the low bits.
    residualCalc = (DIV_SHIFT == 0) ? '0 : RW'(total);
    limitS       = $signed({2'b00, limit});
    limitM1S     = limitS - SW'(1);
    limitM1      = limit - POS_WIDTH'(1);
    raw          = $signed({2'b00, pos}) + SW'(step);

    wrapped = raw;
    if (wrapMode) begin
      if (raw < S_ZERO)        wrapped = raw + limitS;
      else if (raw >= limitS)  wrapped = raw - limitS;
    end

    sat = wrapped;
    if (wrapped < S_ZERO)         sat = S_ZERO;
    else if (wrapped > limitM1S)  sat = limitM1S;

    posNext      = pos;
    residualNext = residual;
    if (recentre) begin
      posNext      = limit >> 1;
      residualNext = '0;
    end else if (deltaValid) begin
      posNext      = POS_WIDTH'(sat);
      residualNext = residualCalc;
    end else if (pos > limitM1) begin
      posNext      = limitM1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pos      <= POS_WIDTH'(RESET_POS);
      residual <= '0;
    end else begin
      pos      <= posNext;
      residual <= residualNext;
    end
  end

endmodule

// File: rtl/mouse_position_tracker.sv
// Absolute cursor X/Y/Z tracker fed by decoded PS/2 packets, with config and an acked interrupt.
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int unsigned POS_WIDTH = 10,
  parameter int unsigned LIMIT_X   = 160,
  parameter int unsigned LIMIT_Y   = 120,
  parameter int unsigned Z_ENABLE  = 1,
  parameter int unsigned Z_WIDTH   = 8,
  parameter int unsigned DIV_SHIFT = 0
) (
  input logic                     CLK,
  input logic                     RESET,
  mouse_position_tracker_if.slave bus
);
  localparam int unsigned ZSW   = ((Z_WIDTH > 8) ? Z_WIDTH : 8) + 1;
  localparam int          Z_MAX = (2 ** (Z_WIDTH - 1)) - 1;
  localparam int          Z_MIN = -Z_MAX - 1;

  logic [POS_WIDTH-1:0]          limitX, limitY, posX, posY;
  logic [1:0]                    mode;
  logic                          recentre;
  logic                          s1Valid;
  logic signed [DELTA_WIDTH-1:0] s1Dx, s1Dy, dyRaw;
  logic signed [7:0]             s1Dz;
  logic [2:0]                    s1Btn;
  logic signed [Z_WIDTH-1:0]     posZ, posZNext;
  logic signed [ZSW-1:0]         zSum;
  intrState_e                    state, stateNext;
  logic                          intr, intrNext;
  logic [2:0]                    buttons, buttonsNext, btnPressed, pressedNext, newPress;
  logic [7:0]                    overrun, overrunNext;
  logic                          unusedStatus;

  assign unusedStatus = bus.PKT_STATUS[3];
  assign recentre     = bus.CFG_WE && (bus.CFG_ADDR == CFG_RECENTRE);

  // Configuration registers; zero limits are rejected so limit-1 stays valid.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      limitX <= POS_WIDTH'(LIMIT_X);
      limitY <= POS_WIDTH'(LIMIT_Y);
      mode   <= '0;
    end else if (bus.CFG_WE) begin
      case (bus.CFG_ADDR)
        CFG_LIMIT_X: if (bus.CFG_WDATA != '0) limitX <= bus.CFG_WDATA;
        CFG_LIMIT_Y: if (bus.CFG_WDATA != '0) limitY <= bus.CFG_WDATA;
        CFG_MODE:    mode <= bus.CFG_WDATA[1:0];
        default:     ;
      endcase
    end
  end

  always_comb dyRaw = formDelta(bus.PKT_STATUS[OVF_Y], bus.PKT_STATUS[SGN_Y], bus.PKT_DY);

  // Stage 1: decoded signed deltas.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1Valid <= 1'b0;
      s1Dx    <= '0;
      s1Dy    <= '0;
      s1Dz    <= '0;
      s1Btn   <= '0;
    end else begin
      s1Valid <= bus.PKT_VALID;
      if (bus.PKT_VALID) begin
        s1Dx  <= formDelta(bus.PKT_STATUS[OVF_X], bus.PKT_STATUS[SGN_X], bus.PKT_DX);
        s1Dy  <= mode[MODE_INVERT_Y] ? -dyRaw : dyRaw;
        s1Dz  <= $signed(bus.PKT_DZ);
        s1Btn <= bus.PKT_STATUS[2:0];
      end
    end
  end

  mouse_axis_accum #(
    .POS_WIDTH (POS_WIDTH),
    .DIV_SHIFT (DIV_SHIFT),
    .RESET_POS (LIMIT_X / 2)
  ) xAxis (
    .CLK        (CLK),
    .RESET      (RESET),
    .deltaValid (s1Valid),
    .delta      (s1Dx),
    .limit      (limitX),
    .wrapMode   (mode[MODE_WRAP]),
    .recentre   (recentre),
    .pos        (posX)
  );

  mouse_axis_accum #(
    .POS_WIDTH (POS_WIDTH),
    .DIV_SHIFT (DIV_SHIFT),
    .RESET_POS (LIMIT_Y / 2)
  ) yAxis (
    .CLK        (CLK),
    .RESET      (RESET),
    .deltaValid (s1Valid),
    .delta      (s1Dy),
    .limit      (limitY),
    .wrapMode   (mode[MODE_WRAP]),
    .recentre   (recentre),
    .pos        (posY)
  );

  // Wheel accumulator saturates to the signed Z range and never wraps.
  always_comb begin
    zSum     = ZSW'(posZ) + ZSW'(s1Dz);
    posZNext = posZ;
    if (recentre || (Z_ENABLE == 0)) begin
      posZNext = '0;
    end else if (s1Valid) begin
      if (zSum > ZSW'(Z_MAX))       posZNext = Z_WIDTH'(Z_MAX);
      else if (zSum < ZSW'(Z_MIN))  posZNext = Z_WIDTH'(Z_MIN);
      else                          posZNext = Z_WIDTH'(zSum);
    end
  end

  // Interrupt FSM next state; an ack coinciding with an update keeps it pending.
  always_comb begin
    stateNext   = state;
    buttonsNext = buttons;
    pressedNext = btnPressed;
    overrunNext = overrun;
    newPress    = s1Valid ? (s1Btn & ~buttons) : 3'b000;
    if (s1Valid) buttonsNext = s1Btn;
    case (state)
      ST_IDLE: begin
        pressedNext = btnPressed | newPress;
        if (s1Valid) stateNext = ST_PENDING;
      end
      ST_PENDING: begin
        if (bus.INTR_ACK) begin
          pressedNext = newPress;
          if (!s1Valid) stateNext = ST_IDLE;
        end else begin
          pressedNext = btnPressed | newPress;
          if (s1Valid && (overrun != 8'hFF)) overrunNext = overrun + 8'd1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
    intrNext = (stateNext == ST_PENDING);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      intr       <= 1'b0;
      buttons    <= '0;
      btnPressed <= '0;
      overrun    <= '0;
      posZ       <= '0;
    end else begin
      state      <= stateNext;
      intr       <= intrNext;
      buttons    <= buttonsNext;
      btnPressed <= pressedNext;
      overrun    <= overrunNext;
      posZ       <= posZNext;
    end
  end

  assign bus.POS_X         = posX;
  assign bus.POS_Y         = posY;
  assign bus.POS_Z         = posZ;
  assign bus.BUTTONS       = buttons;
  assign bus.BTN_PRESSED   = btnPressed;
  assign bus.INTR          = intr;
  assign bus.OVERRUN_COUNT = overrun;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Self-checking bench: packet vector table with a latency-aligned scoreboard plus directed corner cases.
module tb_mouse_position_tracker;
  import mouse_pkg::*;

  localparam int unsigned PW = 10;
  localparam int unsigned ZW = 8;

  typedef struct {
    logic [PW-1:0]        x;
    logic [PW-1:0]        y;
    logic signed [ZW-1:0] z;
    logic                 intr;
    logic [2:0]           btn;
  } expect_t;

  typedef struct {
    logic [7:0]           st, dx, dy, dz;
    logic [PW-1:0]        ex, ey;
    logic signed [ZW-1:0] ez;
    logic [2:0]           eb;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET;
  int   nCmp  = 0;
  int   nFail = 0;
  expect_t sbQ[$];
  logic [1:0] launched;

  always #5 CLK = ~CLK;

  mouse_position_tracker_if #(.POS_WIDTH(PW), .Z_WIDTH(ZW)) bus ();
  mouse_position_tracker_if #(.POS_WIDTH(PW), .Z_WIDTH(ZW)) divBus ();

  mouse_position_tracker #(
    .POS_WIDTH(PW), .LIMIT_X(160), .LIMIT_Y(120), .Z_ENABLE(1), .Z_WIDTH(ZW), .DIV_SHIFT(0)
  ) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  mouse_position_tracker #(
    .POS_WIDTH(PW), .LIMIT_X(160), .LIMIT_Y(120), .Z_ENABLE(1), .Z_WIDTH(ZW), .DIV_SHIFT(2)
  ) divDut (.CLK(CLK), .RESET(RESET), .bus(divBus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  task automatic setPkt(input logic v, input logic [7:0] st, dx, dy, dz);
    bus.PKT_VALID = v;    bus.PKT_STATUS = st;    bus.PKT_DX = dx;    bus.PKT_DY = dy;    bus.PKT_DZ = dz;
    divBus.PKT_VALID = v; divBus.PKT_STATUS = st; divBus.PKT_DX = dx; divBus.PKT_DY = dy; divBus.PKT_DZ = dz;
  endtask

  task automatic setCfg(input logic we, input logic [1:0] addr, input logic [PW-1:0] data);
    bus.CFG_WE = we;    bus.CFG_ADDR = addr;    bus.CFG_WDATA = data;
    divBus.CFG_WE = we; divBus.CFG_ADDR = addr; divBus.CFG_WDATA = data;
  endtask

  task automatic setAck(input logic a);
    bus.INTR_ACK = a;
    divBus.INTR_ACK = a;
  endtask

  task automatic doReset();
    RESET = 1'b1;
    setPkt(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    setCfg(1'b0, 2'd0, '0);
    setAck(1'b0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  // Drives one packet for a cycle and queues the result expected two edges later.
  task automatic sendPkt(input logic [7:0] st, dx, dy, dz, input logic [PW-1:0] ex, ey,
                         input logic signed [ZW-1:0] ez, input logic [2:0] eb);
    expect_t e;
    setPkt(1'b1, st, dx, dy, dz);
    e.x = ex; e.y = ey; e.z = ez; e.intr = 1'b1; e.btn = eb;
    sbQ.push_back(e);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    setPkt(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (n) @(negedge CLK);
  endtask

  task automatic cfgWrite(input logic [1:0] addr, input logic [PW-1:0] data);
    setCfg(1'b1, addr, data);
    @(negedge CLK);
    setCfg(1'b0, 2'd0, '0);
  endtask

  task automatic ackPulse();
    setAck(1'b1);
    @(negedge CLK);
    setAck(1'b0);
    @(negedge CLK);
  endtask

  always @(posedge CLK or posedge RESET) begin
    if (RESET) launched <= 2'b00;
    else       launched <= {launched[0], bus.PKT_VALID};
  end

  always @(negedge CLK) begin
    if (launched[1]) begin
      if (sbQ.size() == 0) begin
        check("sb_unexpected_update", 32'd1, 32'd0);
      end else begin
        expect_t e;
        e = sbQ.pop_front();
        check("sb_posX", 32'(bus.POS_X), 32'(e.x));
        check("sb_posY", 32'(bus.POS_Y), 32'(e.y));
        check("sb_posZ", 32'(bus.POS_Z), 32'(e.z));
        check("sb_intr", 32'(bus.INTR), 32'(e.intr));
        check("sb_buttons", 32'(bus.BUTTONS), 32'(e.btn));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    logic [PW-1:0] divExp[5];
    divExp = '{10'd80, 10'd80, 10'd80, 10'd81, 10'd81};
    vecs[0] = '{8'h00, 8'h0A, 8'h00, 8'h7F, 10'd95,  10'd63,  8'sd127, 3'd0};
    vecs[1] = '{8'h30, 8'hFB, 8'hFE, 8'h05, 10'd90,  10'd61,  8'sd127, 3'd0};
    vecs[2] = '{8'h40, 8'h00, 8'h00, 8'h80, 10'd159, 10'd61,  -8'sd1,  3'd0};
    vecs[3] = '{8'h80, 8'h00, 8'h00, 8'h80, 10'd159, 10'd119, 8'sh80,  3'd0};
    vecs[4] = '{8'hF0, 8'h00, 8'h00, 8'h01, 10'd0,   10'd0,   -8'sd127, 3'd0};
    vecs[5] = '{8'h05, 8'h14, 8'h1E, 8'h00, 10'd20,  10'd30,  -8'sd127, 3'd5};

    // Reset state
    doReset();
    check("rst_posX", 32'(bus.POS_X), 32'd80);
    check("rst_posY", 32'(bus.POS_Y), 32'd60);
    check("rst_posZ", 32'(bus.POS_Z), 32'd0);
    check("rst_intr", 32'(bus.INTR), 32'd0);
    check("rst_buttons", 32'(bus.BUTTONS), 32'd0);
    check("rst_pressed", 32'(bus.BTN_PRESSED), 32'd0);
    check("rst_overrun", 32'(bus.OVERRUN_COUNT), 32'd0);
    check("rst_div_posX", 32'(divBus.POS_X), 32'd80);

    // Basic packet, then acknowledge
    sendPkt(8'h00, 8'h05, 8'h03, 8'h00, 10'd85, 10'd63, 8'sd0, 3'd0);
    idle(2);
    ackPulse();
    check("ack_intr", 32'(bus.INTR), 32'd0);

    // Back-to-back table: overflow, saturation, Z limits, buttons
    foreach (vecs[i])
      sendPkt(vecs[i].st, vecs[i].dx, vecs[i].dy, vecs[i].dz, vecs[i].ex, vecs[i].ey, vecs[i].ez, vecs[i].eb);
    idle(2);
    check("tbl_overrun", 32'(bus.OVERRUN_COUNT), 32'd5);
    check("tbl_pressed", 32'(bus.BTN_PRESSED), 32'd5);
    ackPulse();
    check("tbl_ack_intr", 32'(bus.INTR), 32'd0);
    check("tbl_ack_pressed", 32'(bus.BTN_PRESSED), 32'd0);
    ackPulse();
    check("idle_ack_intr", 32'(bus.INTR), 32'd0);
    check("idle_ack_overrun", 32'(bus.OVERRUN_COUNT), 32'd5);

    // Saturate mode edges
    doReset();
    sendPkt(8'h00, 8'h46, 8'h00, 8'h00, 10'd150, 10'd60, 8'sd0, 3'd0);
    idle(2);
    sendPkt(8'h40, 8'h00, 8'h00, 8'h00, 10'd159, 10'd60, 8'sd0, 3'd0);
    idle(2);
    sendPkt(8'h50, 8'h00, 8'h00, 8'h00, 10'd0, 10'd60, 8'sd0, 3'd0);
    idle(2);

    // Wrap mode with Y inversion
    doReset();
    cfgWrite(CFG_MODE, 10'd3);
    sendPkt(8'h00, 8'h4E, 8'h00, 8'h00, 10'd158, 10'd60, 8'sd0, 3'd0);
    idle(2);
    sendPkt(8'h00, 8'h05, 8'h0A, 8'h00, 10'd3, 10'd50, 8'sd0, 3'd0);
    idle(2);
    sendPkt(8'h10, 8'hF6, 8'h00, 8'h00, 10'd153, 10'd50, 8'sd0, 3'd0);
    idle(2);
    sendPkt(8'h40, 8'h00, 8'h00, 8'h00, 10'd159, 10'd50, 8'sd0, 3'd0);
    idle(2);
    sendPkt(8'h00, 8'h00, 8'h3C, 8'h00, 10'd159, 10'd110, 8'sd0, 3'd0);
    idle(2);

    // Sticky presses, overrun, ack coinciding with an update
    doReset();
    sendPkt(8'h01, 8'h00, 8'h00, 8'h00, 10'd80, 10'd60, 8'sd0, 3'd1);
    idle(2);
    sendPkt(8'h03, 8'h00, 8'h00, 8'h00, 10'd80, 10'd60, 8'sd0, 3'd3);
    idle(2);
    check("btn_pressed_011", 32'(bus.BTN_PRESSED), 32'd3);
    check("btn_overrun_1", 32'(bus.OVERRUN_COUNT), 32'd1);
    sendPkt(8'h04, 8'h00, 8'h00, 8'h00, 10'd80, 10'd60, 8'sd0, 3'd4);
    setPkt(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    setAck(1'b1);
    @(negedge CLK);
    setAck(1'b0);
    @(negedge CLK);
    check("ackupd_intr", 32'(bus.INTR), 32'd1);
    check("ackupd_overrun", 32'(bus.OVERRUN_COUNT), 32'd1);
    check("ackupd_pressed", 32'(bus.BTN_PRESSED), 32'd4);

    // Limit shrink clamp, zero-limit ignored, recentre
    doReset();
    cfgWrite(CFG_LIMIT_X, 10'd50);
    @(negedge CLK);
    check("limit_clamp_posX", 32'(bus.POS_X), 32'd49);
    cfgWrite(CFG_LIMIT_X, 10'd0);
    sendPkt(8'h00, 8'h05, 8'h00, 8'h10, 10'd49, 10'd60, 8'sd16, 3'd0);
    idle(2);
    cfgWrite(CFG_RECENTRE, 10'd0);
    check("recentre_posX", 32'(bus.POS_X), 32'd25);
    check("recentre_posY", 32'(bus.POS_Y), 32'd60);
    check("recentre_posZ", 32'(bus.POS_Z), 32'd0);

    // Sensitivity divide with residual carry on the DIV_SHIFT=2 instance
    doReset();
    for (int k = 0; k < 5; k++) begin
      sendPkt(8'h00, 8'h01, 8'h00, 8'h00, PW'(81 + k), 10'd60, 8'sd0, 3'd0);
      idle(2);
      check("div_posX", 32'(divBus.POS_X), 32'(divExp[k]));
    end

    for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(negedge CLK);
    if (sbQ.size() != 0) check("sb_drain", 32'(sbQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
